// File: rtl/mem_stage.sv
// mem_stage: memory-access stage issuing scalar/vector loads and stores over one data port
module mem_stage #(
    parameter int V = 128,
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         regw_M,
    input  logic         memw_M,
    input  logic         regmem_M,
    input  logic         vec_M,
    input  logic [M-1:0] regScr_M,
    input  logic [N-1:0] ALUrslt_M,
    input  logic [N-1:0] address_M,
    input  logic [V-1:0] regrsltV_M,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_we,
    output logic         mem_re,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic         stall_M,
    output logic         regw_W,
    output logic         regmem_W,
    output logic         vec_W,
    output logic [M-1:0] regScr_W,
    output logic [N-1:0] ALUrslt_W,
    output logic [N-1:0] rdata_W,
    output logic [V-1:0] rdataV_W
);
    localparam int L  = V / N;
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   lane;
    logic            op, last, fin;
    logic [V-1:0]    vbuf, merged;

    assign op   = memw_M | regmem_M;
    assign lane = (vec_M && state == BUSY) ? cnt : '0;
    assign last = vec_M ? (cnt == CW'(L - 1)) : (cnt == '0);
    assign fin  = last & mem_ready;

    // Beat 0 is presented straight from the M inputs; later beats step 4 bytes per lane
    assign mem_addr  = (address_M & ~N'(3)) + (N'(lane) << 2);
    assign mem_wdata = vec_M ? regrsltV_M[N*lane +: N] : ALUrslt_M;

    // State register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    // Next state: stay busy until the last beat is accepted
    always_comb
        state_nx = (state == IDLE) ? ((op && !fin) ? BUSY : IDLE)
                                   : ((!op || fin) ? IDLE : BUSY);

    // Memory requests and stall, all silenced while in reset
    always_comb begin
        mem_we  = !rst && memw_M;
        mem_re  = !rst && op && !memw_M;
        stall_M = !rst && op && !fin;
    end

    // Beat counter advances on each accepted non-final beat
    always_ff @(posedge clk)
        cnt <= (rst || !op || fin) ? '0 : (mem_ready ? cnt + 1'b1 : cnt);

    // Load buffer with the beat completing this cycle merged into its lane
    always_comb begin
        merged = vbuf;
        if (mem_re && mem_ready) merged[N*lane +: N] = mem_rdata;
    end

    // Load buffer register
    always_ff @(posedge clk)
        vbuf <= rst ? '0 : merged;

    // Write-back register: bubble the write enables while stalled, hold the rest
    always_ff @(posedge clk)
        if (rst) begin
            regw_W    <= 1'b0;
            regmem_W  <= 1'b0;
            vec_W     <= 1'b0;
            regScr_W  <= '0;
            ALUrslt_W <= '0;
            rdata_W   <= '0;
            rdataV_W  <= '0;
        end else if (stall_M) begin
            regw_W    <= 1'b0;
            regmem_W  <= 1'b0;
        end else begin
            regw_W    <= regw_M;
            regmem_W  <= regmem_M;
            vec_W     <= vec_M;
            regScr_W  <= regScr_M;
            ALUrslt_W <= ALUrslt_M;
            rdata_W   <= merged[N-1:0];
            rdataV_W  <= merged;
        end
endmodule
